// File: rtl/sd_edge_detect_multi.sv
// sd_edge_detect_multi: per-channel synchroniser, glitch filter and edge
// detector with maskable sticky event flags merged into a single irq line.
module sd_edge_detect_multi #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_CNT  = 0,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] sig,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] flag_clr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] flags,
   output logic             irq
);

   localparam int               CW      = (FILTER_CNT > 0) ? $clog2(FILTER_CNT + 1) : 1;
   localparam logic [CW-1:0]    CNT_MAX = CW'(FILTER_CNT);
   localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_LEVEL}};

   logic [WIDTH-1:0] s;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] set;

   generate
      if (SYNC_STAGES > 0) begin : g_sync
         logic [WIDTH-1:0] chain [SYNC_STAGES];

         // Shift raw inputs through the synchroniser chain
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int unsigned i = 0; i < SYNC_STAGES; i++) chain[i] <= RST_VEC;
            end else begin
               chain[0] <= sig;
               for (int unsigned i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
            end
         end

         // Filter input is the last synchroniser stage
         always_comb s = chain[SYNC_STAGES-1];
      end else begin : g_nosync
         // Input already synchronous: use it directly
         always_comb s = sig;
      end
   endgenerate

   // Glitch filter and edge pulse generation; the counter saturates at
   // FILTER_CNT because it is cleared whenever the level is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= RST_VEC;
         rise  <= '0;
         fall  <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!en) begin
               level[i] <= s[i];
               cnt[i]   <= '0;
               rise[i]  <= 1'b0;
               fall[i]  <= 1'b0;
            end else if (s[i] == level[i]) begin
               cnt[i]  <= '0;
               rise[i] <= 1'b0;
               fall[i] <= 1'b0;
            end else if (cnt[i] == CNT_MAX) begin
               level[i] <= s[i];
               cnt[i]   <= '0;
               rise[i]  <= s[i];
               fall[i]  <= ~s[i];
            end else begin
               cnt[i]  <= cnt[i] + 1'b1;
               rise[i] <= 1'b0;
               fall[i] <= 1'b0;
            end
         end
      end
   end

   // Flag set condition from the registered pulses and masks
   always_comb set = (rise & rise_en) | (fall & fall_en);

   // Sticky flags: set takes priority over clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) flags <= '0;
      else      flags <= set | (flags & ~flag_clr);
   end

   // Interrupt is the OR of all flags
   always_comb irq = |flags;

endmodule

// File: tb/tb_sd_edge_detect_multi.sv
// Testbench for sd_edge_detect_multi: four configurations share one stimulus,
// a window-based reference model is checked every cycle, plus literal checks.
module tb_sd_edge_detect_multi;

   localparam int NI   = 4;
   localparam int HMAX = 2048;
   localparam int SS  [NI] = '{0, 2, 2, 2};
   localparam int FF  [NI] = '{0, 0, 3, 3};
   localparam int RLV [NI] = '{0, 0, 0, 1};
   localparam int WW  [NI] = '{1, 4, 4, 4};

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] sig, rise_en, fall_en, flag_clr;

   logic       l1, r1, f1, fl1, iq1;
   logic [3:0] l2, r2, f2, fl2;
   logic [3:0] l3, r3, f3, fl3;
   logic [3:0] l4, r4, f4, fl4;
   logic       iq2, iq3, iq4;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   sd_edge_detect_multi #(.WIDTH(1), .SYNC_STAGES(0), .FILTER_CNT(0), .RESET_LEVEL(1'b0)) d1 (
      .clk(clk), .rst(rst), .en(en), .sig(sig[0:0]), .rise_en(rise_en[0:0]),
      .fall_en(fall_en[0:0]), .flag_clr(flag_clr[0:0]), .level(l1), .rise(r1),
      .fall(f1), .flags(fl1), .irq(iq1));

   sd_edge_detect_multi #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CNT(0), .RESET_LEVEL(1'b0)) d2 (
      .clk(clk), .rst(rst), .en(en), .sig(sig), .rise_en(rise_en), .fall_en(fall_en),
      .flag_clr(flag_clr), .level(l2), .rise(r2), .fall(f2), .flags(fl2), .irq(iq2));

   sd_edge_detect_multi #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .RESET_LEVEL(1'b0)) d3 (
      .clk(clk), .rst(rst), .en(en), .sig(sig), .rise_en(rise_en), .fall_en(fall_en),
      .flag_clr(flag_clr), .level(l3), .rise(r3), .fall(f3), .flags(fl3), .irq(iq3));

   sd_edge_detect_multi #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .RESET_LEVEL(1'b1)) d4 (
      .clk(clk), .rst(rst), .en(en), .sig(sig), .rise_en(rise_en), .fall_en(fall_en),
      .flag_clr(flag_clr), .level(l4), .rise(r4), .fall(f4), .flags(fl4), .irq(iq4));

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Input history per clock edge; a level change is accepted when the last
   // FILTER_CNT+1 enabled post-reset samples of the delayed input all show it.
   logic [3:0] sig_h [HMAX];
   logic       en_h  [HMAX];
   int         n      = 0;
   int         rstart = 0;
   logic [3:0] m_level [NI], m_rise [NI], m_fall [NI], m_flags [NI];

   function automatic logic s_at(int k, int ch, int m);
      if (m - SS[k] >= rstart) return sig_h[m - SS[k]][ch];
      return RLV[k] != 0;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rstart = n;
         for (int k = 0; k < NI; k++) begin
            m_level[k] = (RLV[k] != 0) ? 4'hF : 4'h0;
            m_rise[k]  = '0;
            m_fall[k]  = '0;
            m_flags[k] = '0;
         end
      end else begin
         if (n >= HMAX) begin
            $display("FAIL history: edge count %0d exceeds %0d", n, HMAX);
            $fatal(1);
         end
         sig_h[n] = sig;
         en_h[n]  = en;
         for (int k = 0; k < NI; k++) begin
            for (int ch = 0; ch < WW[k]; ch++) begin
               logic sv, ok, nr, nf;
               sv = s_at(k, ch, n);
               if ((m_rise[k][ch] && rise_en[ch]) || (m_fall[k][ch] && fall_en[ch]))
                  m_flags[k][ch] = 1'b1;
               else if (flag_clr[ch])
                  m_flags[k][ch] = 1'b0;
               nr = 1'b0;
               nf = 1'b0;
               if (!en) begin
                  m_level[k][ch] = sv;
               end else if (sv != m_level[k][ch]) begin
                  ok = 1'b1;
                  for (int j = 0; j <= FF[k]; j++) begin
                     if (n - j < rstart) ok = 1'b0;
                     else if (!en_h[n-j] || s_at(k, ch, n - j) != sv) ok = 1'b0;
                  end
                  if (ok) begin
                     m_level[k][ch] = sv;
                     nr = sv;
                     nf = !sv;
                  end
               end
               m_rise[k][ch] = nr;
               m_fall[k][ch] = nf;
            end
         end
         n++;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_on) begin
         logic [3:0] al [NI], ar [NI], af [NI], afl [NI], ai [NI];
         logic [3:0] mask;
         al  = '{{3'b0, l1}, l2, l3, l4};
         ar  = '{{3'b0, r1}, r2, r3, r4};
         af  = '{{3'b0, f1}, f2, f3, f4};
         afl = '{{3'b0, fl1}, fl2, fl3, fl4};
         ai  = '{{3'b0, iq1}, {3'b0, iq2}, {3'b0, iq3}, {3'b0, iq4}};
         for (int k = 0; k < NI; k++) begin
            mask = (WW[k] == 4) ? 4'hF : 4'h1;
            check($sformatf("d%0d level", k + 1), al[k] & mask, m_level[k] & mask);
            check($sformatf("d%0d rise", k + 1), ar[k] & mask, m_rise[k] & mask);
            check($sformatf("d%0d fall", k + 1), af[k] & mask, m_fall[k] & mask);
            check($sformatf("d%0d flags", k + 1), afl[k] & mask, m_flags[k] & mask);
            check($sformatf("d%0d irq", k + 1), ai[k], {3'b0, |(m_flags[k] & mask)});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) tick();
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; en = 1'b1; sig = '0;
      rise_en = '0; fall_en = '0; flag_clr = '0;
      #1 rst = 1'b0;
      cmp_on = 1'b1;
      #1;
      check("reset d2 level", l2, 4'b0000);
      check("reset d4 level", l4, 4'b1111);
      check("reset d4 flags", fl4, 4'b0000);
      check("reset d4 irq", {3'b0, iq4}, 4'b0000);
      tick(); tick();
      rst = 1'b1;
      idle(12);

      // Legacy timing, single-cycle input pulse
      sig = 4'b0001;
      tick(); check("t1 rise", {3'b0, r1}, 4'b0001);
      sig = 4'b0000;
      tick(); check("t1 fall", {3'b0, f1}, 4'b0001); check("t1 rise gone", {3'b0, r1}, 4'b0000);
      tick(); check("t1 quiet", {3'b0, r1 | f1}, 4'b0000);
      idle(8);
      // Legacy timing, three-cycle input pulse
      sig = 4'b0001;
      tick(); check("t1b rise", {3'b0, r1}, 4'b0001);
      tick(); check("t1b single rise", {3'b0, r1}, 4'b0000); check("t1b level", {3'b0, l1}, 4'b0001);
      tick();
      sig = 4'b0000;
      tick(); check("t1b fall", {3'b0, f1}, 4'b0001);
      tick(); check("t1b single fall", {3'b0, f1}, 4'b0000);
      idle(8);

      // Synchroniser latency
      sig = 4'b0001;
      tick(); check("t2 edge k", r2, 4'b0000);
      tick(); check("t2 edge k+1", r2, 4'b0000);
      tick(); check("t2 edge k+2 rise", r2, 4'b0001); check("t2 level", l2, 4'b0001);
      tick(); check("t2 pulse width", r2, 4'b0000); check("t2 level held", l2, 4'b0001);
      sig = 4'b0000;
      idle(10);

      // Glitch shorter than the filter window
      sig = 4'b0100;
      idle(3);
      sig = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick(); check("t3 glitch no rise", r3, 4'b0000);
      end
      check("t3 glitch level", l3, 4'b0000);
      // Long enough pulse
      sig = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick(); check("t3 early rise", r3, 4'b0000);
      end
      tick(); check("t3 rise at k+5", r3, 4'b0100);
      tick(); check("t3 pulse width", r3, 4'b0000); check("t3 level", l3, 4'b0100);
      idle(3);
      sig = 4'b0000;
      idle(12);

      // Flags and masks
      rise_en = 4'b0011; fall_en = 4'b0100;
      sig = 4'b1111;
      idle(10);
      check("t4 rise flags", fl2, 4'b0011);
      check("t4 irq", {3'b0, iq2}, 4'b0001);
      check("t4 d3 rise flags", fl3, 4'b0011);
      sig = 4'b0000;
      idle(10);
      check("t4 fall flags", fl2, 4'b0111);
      flag_clr = 4'b0111;
      tick();
      flag_clr = 4'b0000;
      check("t4 cleared", fl2, 4'b0000);
      check("t4 irq cleared", {3'b0, iq2}, 4'b0000);
      // Set coincides with clear on d1 channel 0
      sig = 4'b0001;
      tick(); check("t4 d1 rise", {3'b0, r1}, 4'b0001);
      flag_clr = 4'b0001;
      tick();
      flag_clr = 4'b0000;
      check("t4 set beats clear", {3'b0, fl1}, 4'b0001);
      sig = 4'b0000;
      idle(10);
      flag_clr = 4'b1111;
      tick();
      flag_clr = 4'b0000;
      check("t4 all clear", fl2, 4'b0000);

      // Enable gating
      en = 1'b0;
      sig = 4'b0010;
      idle(3);
      check("t5 level tracks", l2, 4'b0010);
      check("t5 no rise", r2, 4'b0000);
      check("t5 flags hold", fl2, 4'b0000);
      idle(3);
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(); check("t5 no pulse on enable", r2 | f2, 4'b0000);
      end
      check("t5 flags after enable", fl2, 4'b0000);

      // Reset mid-filter with RESET_LEVEL=1
      sig = 4'b1111;
      idle(10);
      flag_clr = 4'b1111;
      tick();
      flag_clr = 4'b0000;
      sig = 4'b1011;
      idle(8);
      check("t6 d4 level before", l4, 4'b1011);
      check("t6 d4 flags before", fl4, 4'b0100);
      sig = 4'b1111;
      idle(3);
      rst = 1'b0;
      #1;
      check("t6 async level", l4, 4'b1111);
      check("t6 async flags", fl4, 4'b0000);
      check("t6 async pulses", r4 | f4, 4'b0000);
      check("t6 async irq", {3'b0, iq4}, 4'b0000);
      idle(2);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t6 no pulse after release", r4 | f4, 4'b0000);
         check("t6 level after release", l4, 4'b1111);
      end

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
